// File: rtl/prog_readback_if.sv
// Program-memory read port between the readback block and the 1R1W RAM.
// Master drives the address; slave returns the synchronous read word.
interface prog_readback_if;
  logic [7:0]  addrRd;
  logic [15:0] dataRd;

  modport master (
    output addrRd,
    input  dataRd
  );

  modport slave (
    input  addrRd,
    output dataRd
  );
endinterface

// File: rtl/prog_readback.sv
// Program-RAM readback: operator picks an address on the switches and
// steps through 16-bit words, one byte at a time on the LEDs.
module prog_readback #(
  parameter int DEB_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             switch,
  input  logic                   enter,
  prog_readback_if.master        mem,
  output logic [7:0]             outPattern,
  output logic [1:0]             phase
);

  localparam logic [1:0] S_ADDR = 2'b00;
  localparam logic [1:0] S_READ = 2'b01;
  localparam logic [1:0] S_HI   = 2'b10;
  localparam logic [1:0] S_LO   = 2'b11;

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_deb;
  logic          r_deb_d;
  logic          r_armed;
  logic [1:0]    r_vld;
  logic [CW-1:0] r_cnt;

  logic [1:0]    r_state;
  logic          r_wait;
  logic [7:0]    r_addr;
  logic [7:0]    r_out;
  logic [15:0]   r_word;

  logic          w_press;

  // Presses are armed only once a released level has passed the
  // synchronizer, so a button held through reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_armed <= 1'b0;
      r_vld   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= enter;
      r_sync1 <= r_sync0;
      r_vld   <= {r_vld[0], 1'b1};
      r_deb_d <= r_deb;
      if (r_vld[1] && !r_sync1)
        r_armed <= 1'b1;
      if (r_sync1 != r_deb) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_deb <= r_sync1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign w_press = r_armed & r_deb & ~r_deb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ADDR;
      r_wait  <= 1'b0;
      r_addr  <= 8'h00;
      r_word  <= 16'h0000;
      r_out   <= 8'h00;
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (w_press) begin
            r_addr  <= switch;
            r_wait  <= 1'b0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (!r_wait) begin
            r_wait <= 1'b1;
          end else begin
            r_word  <= mem.dataRd;
            r_out   <= mem.dataRd[15:8];
            r_wait  <= 1'b0;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          if (w_press) begin
            r_out   <= r_word[7:0];
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (w_press) begin
            r_addr  <= r_addr + 8'h01;
            r_wait  <= 1'b0;
            r_state <= S_READ;
          end
        end
      endcase
    end
  end

  assign mem.addrRd = r_addr;
  assign outPattern = r_out;
  assign phase      = r_state;

endmodule

// File: tb/tb_prog_readback.sv
// Bench for prog_readback: scoreboard of expected LED bytes plus
// per-scenario timing checks on a fast and a slow-debounce instance.
module tb_prog_readback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  switch = 8'h00;
  logic        enter = 1'b0;
  logic        enter2 = 1'b0;
  logic [7:0]  out1;
  logic [7:0]  out2;
  logic [1:0]  ph1;
  logic [1:0]  ph2;
  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [1:0] prev_ph = 2'b00;
  logic [7:0] exp_b;

  prog_readback_if m1();
  prog_readback_if m2();

  prog_readback #(.DEB_CYCLES(1)) u_dut (
    .clk(clk),
    .rst(rst),
    .switch(switch),
    .enter(enter),
    .mem(m1.master),
    .outPattern(out1),
    .phase(ph1)
  );

  prog_readback #(.DEB_CYCLES(4)) u_deb (
    .clk(clk),
    .rst(rst),
    .switch(switch),
    .enter(enter2),
    .mem(m2.master),
    .outPattern(out2),
    .phase(ph2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m1.dataRd <= mem[m1.addrRd];
    m2.dataRd <= mem[m2.addrRd];
  end

  // Scoreboard: every new HI/LO display must match the next queued byte.
  always @(negedge clk) begin
    if (ph1 !== prev_ph && (ph1 === 2'b10 || ph1 === 2'b11)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty phase=%b out=%h", ph1, out1);
      end else begin
        exp_b = q.pop_front();
        if (out1 !== exp_b) begin
          errors++;
          $display("FAIL scoreboard_byte got=%h exp=%h", out1, exp_b);
        end
      end
    end
    prev_ph = ph1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    q.delete();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic press_main(input logic [7:0] exp);
    q.push_back(exp);
    enter = 1'b1;
    repeat (4) tick();
    enter = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    enter = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++;
    if (ph1 !== 2'b00 || out1 !== 8'h00 || m1.addrRd !== 8'h00) begin
      errors++;
      $display("FAIL reset_state ph=%b out=%h addr=%h exp 00/00/00",
               ph1, out1, m1.addrRd);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ph1 !== 2'b00) begin
        errors++;
        $display("FAIL held_enter cyc=%0d ph=%b exp=00", i, ph1);
      end
    end
    enter = 1'b0;
    repeat (6) tick();
    switch = 8'h10;
    press_main(8'h77);
    checks++;
    if (ph1 !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_press ph=%b exp=10", ph1);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    switch = 8'h05;
    q.push_back(8'hA5);
    enter = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 3) begin
        checks++;
        if (ph1 !== 2'b00) begin
          errors++;
          $display("FAIL early_press ph=%b exp=00", ph1);
        end
      end
      if (k == 4) begin
        enter = 1'b0;
        checks++;
        if (ph1 !== 2'b01 || m1.addrRd !== 8'h05) begin
          errors++;
          $display("FAIL read_entry ph=%b addr=%h exp 01/05", ph1, m1.addrRd);
        end
      end
      if (k == 5) begin
        checks++;
        if (ph1 !== 2'b01) begin
          errors++;
          $display("FAIL read_cycle2 ph=%b exp=01", ph1);
        end
      end
      if (k == 6) begin
        checks++;
        if (ph1 !== 2'b10) begin
          errors++;
          $display("FAIL read_done ph=%b exp=10", ph1);
        end
      end
    end
    repeat (6) tick();
    press_main(8'h3C);
    checks++;
    if (ph1 !== 2'b11) begin
      errors++;
      $display("FAIL low_phase ph=%b exp=11", ph1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    switch = 8'hFF;
    press_main(8'h12);
    press_main(8'h34);
    switch = 8'h40;
    press_main(8'hBE);
    checks++;
    if (m1.addrRd !== 8'h00 || ph1 !== 2'b10) begin
      errors++;
      $display("FAIL wrap_addr addr=%h ph=%b exp 00/10", m1.addrRd, ph1);
    end
    press_main(8'hEF);
    checks++;
    if (ph1 !== 2'b11 || out1 !== 8'hEF) begin
      errors++;
      $display("FAIL wrap_low ph=%b out=%h exp 11/EF", ph1, out1);
    end
  endtask

  task automatic test_debounce();
    int lens[2] = '{1, 3};
    do_reset();
    switch = 8'h05;
    foreach (lens[j]) begin
      enter2 = 1'b1;
      repeat (lens[j]) tick();
      enter2 = 1'b0;
      repeat (12) tick();
      checks++;
      if (ph2 !== 2'b00) begin
        errors++;
        $display("FAIL glitch_%0d ph=%b exp=00", lens[j], ph2);
      end
    end
    enter2 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) enter2 = 1'b0;
      if (k == 6) begin
        checks++;
        if (ph2 !== 2'b00) begin
          errors++;
          $display("FAIL deb_latency_early ph=%b exp=00", ph2);
        end
      end
      if (k == 7) begin
        checks++;
        if (ph2 !== 2'b01 || m2.addrRd !== 8'h05) begin
          errors++;
          $display("FAIL deb_latency ph=%b addr=%h exp 01/05", ph2, m2.addrRd);
        end
      end
    end
    repeat (3) tick();
    checks++;
    if (ph2 !== 2'b10 || out2 !== 8'hA5) begin
      errors++;
      $display("FAIL deb_read ph=%b out=%h exp 10/A5", ph2, out2);
    end
  endtask

  task automatic test_drop();
    do_reset();
    switch = 8'h05;
    q.push_back(8'hA5);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      tick();
      checks++;
      if (ph1 !== ((k == 6) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL drop_seq edge=%0d ph=%b", k, ph1);
      end
    end
    repeat (10) tick();
    checks++;
    if (ph1 !== 2'b10 || m1.addrRd !== 8'h05 || out1 !== 8'hA5) begin
      errors++;
      $display("FAIL drop_hold ph=%b addr=%h out=%h exp 10/05/A5",
               ph1, m1.addrRd, out1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    switch = 8'h05;
    q.push_back(8'hA5);
    enter = 1'b1;
    repeat (4) tick();
    enter = 1'b0;
    checks++;
    if (ph1 !== 2'b01) begin
      errors++;
      $display("FAIL mid_entry ph=%b exp=01", ph1);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    checks++;
    if (ph1 !== 2'b00 || out1 !== 8'h00 || m1.addrRd !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset ph=%b out=%h addr=%h exp 00/00/00",
               ph1, out1, m1.addrRd);
    end
    repeat (4) tick();
    press_main(8'hA5);
    press_main(8'h3C);
    checks++;
    if (ph1 !== 2'b11) begin
      errors++;
      $display("FAIL mid_reread ph=%b exp=11", ph1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
    mem[8'h05] = 16'hA53C;
    mem[8'h10] = 16'h7788;
    mem[8'hFF] = 16'h1234;
    mem[8'h00] = 16'hBEEF;
    test_reset();
    test_single_read();
    test_wrap();
    test_debounce();
    test_drop();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
